mouse_init_sequencer: RTL and testbench
=======================================

MOUSE_INIT_SEQUENCER -- requirements
Module: mouse_init_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 25_000_000, max cycles spent in any wait state (0.5 s at 50 MHz).
REQ-002 SHALL have parameter MAX_RETRIES, default 3, init-sequence restarts allowed before failure.
REQ-003 SHALL use one clock and a synchronous, active-high reset: Clk in 1, rising-edge clock; Reset in 1, synchronous active-high reset.
REQ-004 TxData out 8: command byte to the PS/2 transceiver.
REQ-005 TxStart out 1: one-cycle send request; TxData stable in that cycle.
REQ-006 TxDone in 1: one-cycle pulse, byte transmitted.
REQ-007 TxError in 1: one-cycle pulse, transmission failed.
REQ-008 RxData in 8: received byte; valid only while RxValid=1.
REQ-009 RxValid in 1: one-cycle pulse, received byte.
REQ-010 Ready out 1: high while in STREAM.
REQ-011 Error out 1: sticky failure flag.
REQ-012 PacketValid out 1: one-cycle pulse, new packet on outputs.
REQ-013 Buttons out 3: {middle, right, left}.
REQ-014 DeltaX, DeltaY out 9 each: two's-complement movement.
REQ-015 Overflow out 2: {Y overflow, X overflow}.

Function
REQ-016 States SHALL be SEND_RST, WAIT_ACK_RST, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_ACK_EN, STREAM, FAIL.
REQ-017 SEND_x: assert TxStart for exactly one cycle with TxData 0xFF (SEND_RST) or 0xF4 (SEND_EN), then hold TxStart low until TxDone/TxError.
REQ-018 TxDone advances to the next WAIT state; TxError counts as a failed attempt (REQ-022).
REQ-019 WAIT_ACK_RST expects 0xFA, WAIT_BAT expects 0xAA, WAIT_ID expects 0x00, WAIT_ACK_EN expects 0xFA; a match advances: WAIT_ACK_EN -> STREAM.
REQ-020 In WAIT_ACK_*, 0xFE (resend) re-enters the matching SEND state and counts as a failed attempt.
REQ-021 The timeout counter clears on entry to every WAIT/SEND state; reaching TIMEOUT_CYCLES is a failed attempt.
REQ-022 Failed attempt (wrong byte, timeout, TxError, 0xFE): retry counter += 1; if it then exceeds MAX_RETRIES -> FAIL, otherwise -> SEND_RST (or the resend target).
REQ-023 RxValid and timeout in the same cycle: RxValid wins; timeout ignored.
REQ-024 RxValid in SEND states and FAIL is ignored.
REQ-025 FAIL is absorbing until Reset; Error=1, Ready=0, no TxStart.
REQ-026 STREAM: byte index 0..2; byte 0 accepted only if bit3=1, otherwise discarded with index held at 0.
REQ-027 STREAM: index 1 or 2 with no RxValid for TIMEOUT_CYCLES -> index 0; state stays STREAM.
REQ-028 On the third byte, outputs register in the next cycle with PacketValid=1: Buttons=b0[2:0], DeltaX={b0[4],b1}, DeltaY={b0[5],b2}, Overflow={b0[7],b0[6]}.
REQ-029 Packet outputs hold until the next packet; PacketValid is high exactly one cycle per packet.
REQ-030 Retry counter clears on entering STREAM.

Reset
REQ-031 Reset SHALL force state SEND_RST and clear the retry, timeout and byte-index counters.
REQ-032 Reset SHALL drive TxStart=0, TxData=0x00, Ready=0, Error=0, PacketValid=0, Buttons=0, DeltaX=0, DeltaY=0, Overflow=0.
REQ-033 Reset mid-transmission or mid-packet SHALL discard all progress; the first TxStart follows in the cycle after Reset deasserts.

Structure
REQ-034 Package mouse_pkg SHALL hold the state encoding and the byte constants CMD_RESET 0xFF, CMD_ENABLE 0xF4, RSP_ACK 0xFA, RSP_RESEND 0xFE, RSP_BAT 0xAA, RSP_ID 0x00.
REQ-035 Sub-module sequencer_timer SHALL implement the clearable timeout counter (clear in, expired out); width $clog2(TIMEOUT_CYCLES+1).

Verification (TIMEOUT_CYCLES=100, MAX_RETRIES=3)
REQ-036 Bench SHALL cover happy path: Reset release -> TxStart with 0xFF; TxDone, Rx FA, AA, 00 -> TxStart with 0xF4; TxDone, Rx FA -> Ready=1.
REQ-037 Bench SHALL cover packet: Rx 0x09, 0x05, 0xFB -> one cycle later PacketValid=1, Buttons=001, DeltaX=+5, DeltaY=+251 (0x0FB); then Rx 0x29, 0x05, 0xFB -> DeltaY=-5 (0x1FB).
REQ-038 Bench SHALL cover resync: Rx 0x01 (bit3=0) -> discarded, no PacketValid; Rx 0x08 then silence for 100 cycles -> index 0; next 0x08, 0x00, 0x00 -> PacketValid=1 with zeros.
REQ-039 Bench SHALL cover retries: no response after each 0xFF -> four TxStart pulses with 0xFF, then Error=1 permanently; Reset clears Error.
REQ-040 Bench SHALL cover the tie: RxValid with 0xFA in the cycle the timeout expires in WAIT_ACK_RST -> advances to WAIT_BAT, retry counter unchanged.
REQ-041 Bench SHALL cover resend: Rx 0xFE in WAIT_ACK_EN -> TxStart with 0xF4 again; Rx 0xFA then -> Ready=1.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared state encoding, PS/2 command/response bytes and sequencing helpers
// for the mouse initialisation sequencer.
package mouse_pkg;

    typedef enum logic [2:0] {
        SEND_RST,
        WAIT_ACK_RST,
        WAIT_BAT,
        WAIT_ID,
        SEND_EN,
        WAIT_ACK_EN,
        STREAM,
        FAIL
    } state_e;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_BAT    = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    // Successor of each step of the init sequence on success.
    function automatic state_e next_state(input state_e s);
        case (s)
            SEND_RST:     next_state = WAIT_ACK_RST;
            WAIT_ACK_RST: next_state = WAIT_BAT;
            WAIT_BAT:     next_state = WAIT_ID;
            WAIT_ID:      next_state = SEND_EN;
            SEND_EN:      next_state = WAIT_ACK_EN;
            WAIT_ACK_EN:  next_state = STREAM;
            default:      next_state = s;
        endcase
    endfunction

    function automatic logic [7:0] expected_rsp(input state_e s);
        case (s)
            WAIT_ACK_RST, WAIT_ACK_EN: expected_rsp = RSP_ACK;
            WAIT_BAT:                  expected_rsp = RSP_BAT;
            default:                   expected_rsp = RSP_ID;
        endcase
    endfunction

endpackage

// File: rtl/sequencer_timer.sv
// Clearable saturating cycle counter; expired stays high once the limit is
// reached until the next clear.
module sequencer_timer #(
    parameter int TIMEOUT_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (count_q != LIMIT)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mouse_init_sequencer.sv
// PS/2 mouse bring-up: reset/BAT/ID/enable handshake with bounded retries,
// then 3-byte stream packet assembly.
module mouse_init_sequencer
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 25_000_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic [7:0] TxData,
    output logic       TxStart,
    input  logic       TxDone,
    input  logic       TxError,
    input  logic [7:0] RxData,
    input  logic       RxValid,
    output logic       Ready,
    output logic       Error,
    output logic       PacketValid,
    output logic [2:0] Buttons,
    output logic [8:0] DeltaX,
    output logic [8:0] DeltaY,
    output logic [1:0] Overflow
);
    localparam int RW = $clog2(MAX_RETRIES + 2);

    state_e        state_q, state_d;
    logic          sent_q, sent_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    hdr_q, hdr_d;   // byte 0 without its always-one bit 3
    logic [7:0]    b1_q, b1_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic [2:0]    buttons_q, buttons_d;
    logic [8:0]    dx_q, dx_d, dy_q, dy_d;
    logic [1:0]    ovf_q, ovf_d;

    logic   timer_clear, timer_expired;
    logic   advance, fail_attempt;
    state_e fail_target;

    sequencer_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (Clk),
        .rst     (Reset),
        .clear   (timer_clear),
        .expired (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        sent_d       = sent_q;
        retry_d      = retry_q;
        idx_d        = idx_q;
        hdr_d        = hdr_q;
        b1_d         = b1_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        pkt_valid_d  = 1'b0;
        buttons_d    = buttons_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        ovf_d        = ovf_q;
        timer_clear  = 1'b0;
        advance      = 1'b0;
        fail_attempt = 1'b0;
        fail_target  = SEND_RST;

        case (state_q)
            SEND_RST, SEND_EN: begin
                if (!sent_q) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = (state_q == SEND_RST) ? CMD_RESET : CMD_ENABLE;
                    sent_d     = 1'b1;
                end else if (TxDone) begin
                    advance = 1'b1;
                end else if (TxError || timer_expired) begin
                    fail_attempt = 1'b1;
                end
            end
            WAIT_ACK_RST, WAIT_BAT, WAIT_ID, WAIT_ACK_EN: begin
                // A byte arriving in the expiry cycle takes precedence.
                if (RxValid) begin
                    if (RxData == expected_rsp(state_q)) begin
                        advance = 1'b1;
                    end else begin
                        fail_attempt = 1'b1;
                        if (state_q == WAIT_ACK_EN && RxData == RSP_RESEND)
                            fail_target = SEND_EN;
                    end
                end else if (timer_expired) begin
                    fail_attempt = 1'b1;
                end
            end
            STREAM: begin
                if (RxValid) begin
                    timer_clear = 1'b1;
                    case (idx_q)
                        2'd0: begin
                            if (RxData[3]) begin
                                hdr_d = {RxData[7:4], RxData[2:0]};
                                idx_d = 2'd1;
                            end
                        end
                        2'd1: begin
                            b1_d  = RxData;
                            idx_d = 2'd2;
                        end
                        default: begin
                            idx_d       = 2'd0;
                            pkt_valid_d = 1'b1;
                            buttons_d   = hdr_q[2:0];
                            dx_d        = {hdr_q[3], b1_q};
                            dy_d        = {hdr_q[4], RxData};
                            ovf_d       = hdr_q[6:5];
                        end
                    endcase
                end else if (timer_expired && idx_q != 2'd0) begin
                    idx_d = 2'd0;
                end
            end
            default: ;
        endcase

        if (advance) begin
            state_d     = next_state(state_q);
            sent_d      = 1'b0;
            timer_clear = 1'b1;
            if (next_state(state_q) == STREAM) begin
                retry_d = '0;
                idx_d   = 2'd0;
            end
        end

        if (fail_attempt) begin
            retry_d     = retry_q + 1'b1;
            state_d     = (int'(retry_q) + 1 > MAX_RETRIES) ? FAIL : fail_target;
            sent_d      = 1'b0;
            timer_clear = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= SEND_RST;
            sent_q      <= 1'b0;
            retry_q     <= '0;
            idx_q       <= 2'd0;
            hdr_q       <= '0;
            b1_q        <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            pkt_valid_q <= 1'b0;
            buttons_q   <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            sent_q      <= sent_d;
            retry_q     <= retry_d;
            idx_q       <= idx_d;
            hdr_q       <= hdr_d;
            b1_q        <= b1_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            pkt_valid_q <= pkt_valid_d;
            buttons_q   <= buttons_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign TxStart     = tx_start_q;
    assign TxData      = tx_data_q;
    assign Ready       = (state_q == STREAM);
    assign Error       = (state_q == FAIL);
    assign PacketValid = pkt_valid_q;
    assign Buttons     = buttons_q;
    assign DeltaX      = dx_q;
    assign DeltaY      = dy_q;
    assign Overflow    = ovf_q;

endmodule

// File: tb/tb_mouse_init_sequencer.sv
// Bench for mouse_init_sequencer: init handshake, retries, tie, resend,
// table-driven packets and randomized packets against a decoding model.
module tb_mouse_init_sequencer;
    localparam int TO = 100;
    localparam int MR = 3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] TxData;
    logic       TxStart;
    logic       TxDone = 1'b0;
    logic       TxError = 1'b0;
    logic [7:0] RxData = 8'h00;
    logic       RxValid = 1'b0;
    logic       Ready, Error, PacketValid;
    logic [2:0] Buttons;
    logic [8:0] DeltaX, DeltaY;
    logic [1:0] Overflow;

    int n_checks = 0;
    int n_fail   = 0;

    mouse_init_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
        .Clk(Clk), .Reset(Reset), .TxData(TxData), .TxStart(TxStart),
        .TxDone(TxDone), .TxError(TxError), .RxData(RxData), .RxValid(RxValid),
        .Ready(Ready), .Error(Error), .PacketValid(PacketValid), .Buttons(Buttons),
        .DeltaX(DeltaX), .DeltaY(DeltaY), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic [2:0] btn;
        logic [8:0] dx, dy;
        logic [1:0] ovf;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic rx(input logic [7:0] b);
        RxData  = b;
        RxValid = 1'b1;
        step();
        RxValid = 1'b0;
    endtask

    task automatic txdone();
        TxDone = 1'b1;
        step();
        TxDone = 1'b0;
    endtask

    task automatic txerr();
        TxError = 1'b1;
        step();
        TxError = 1'b0;
    endtask

    task automatic wait_start(input logic [7:0] exp, input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (TxStart) seen = 1;
            else step();
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, "_data"}, 32'(TxData), 32'(exp));
            step();
            check({name, "_1cyc"}, 32'(TxStart), 32'd0);
        end
    endtask

    // Holds reset, checks cleared outputs, releases and checks the first 0xFF.
    task automatic do_reset();
        Reset = 1'b1;
        repeat (3) step();
        check("rst_txstart", 32'(TxStart), 32'd0);
        check("rst_txdata", 32'(TxData), 32'd0);
        check("rst_ready", 32'(Ready), 32'd0);
        check("rst_error", 32'(Error), 32'd0);
        check("rst_pv", 32'(PacketValid), 32'd0);
        check("rst_pkt", 32'({Buttons, DeltaX, DeltaY, Overflow}), 32'd0);
        Reset = 1'b0;
        step();
        check("first_txstart", 32'(TxStart), 32'd1);
        check("first_txdata", 32'(TxData), 32'hFF);
        step();
        check("first_txstart_1cyc", 32'(TxStart), 32'd0);
    endtask

    task automatic init_to_stream();
        txdone();
        rx(8'hFA);
        rx(8'hAA);
        rx(8'h00);
        wait_start(8'hF4, "en_start");
        txdone();
        check("ready_before_ack", 32'(Ready), 32'd0);
        rx(8'hFA);
        check("ready_after_ack", 32'(Ready), 32'd1);
    endtask

    // Reference decode of a complete packet from the three raw bytes.
    task automatic check_pkt(input string name, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
        int sx, sy;
        sx = (b0 & 8'h10) != 0 ? int'(b1) - 256 : int'(b1);
        sy = (b0 & 8'h20) != 0 ? int'(b2) - 256 : int'(b2);
        check({name, "_pv"}, 32'(PacketValid), 32'd1);
        check({name, "_btn"}, 32'(Buttons), 32'(int'(b0) % 8));
        check({name, "_dx"}, 32'(int'($signed(DeltaX))), 32'(sx));
        check({name, "_dy"}, 32'(int'($signed(DeltaY))), 32'(sy));
        check({name, "_ovf"}, 32'(Overflow), 32'(int'(b0) / 64));
    endtask

    initial begin
        tbl[0] = '{8'h09, 8'h05, 8'hFB, 3'b001, 9'h005, 9'h0FB, 2'b00};
        tbl[1] = '{8'h29, 8'h05, 8'hFB, 3'b001, 9'h005, 9'h1FB, 2'b00};
        tbl[2] = '{8'h1A, 8'hFF, 8'h00, 3'b010, 9'h1FF, 9'h000, 2'b00};
        tbl[3] = '{8'hCF, 8'h80, 8'h7F, 3'b111, 9'h080, 9'h07F, 2'b11};
        tbl[4] = '{8'h38, 8'h00, 8'h00, 3'b000, 9'h100, 9'h100, 2'b00};
        tbl[5] = '{8'h4C, 8'h12, 8'h34, 3'b100, 9'h012, 9'h034, 2'b01};

        // Happy path
        do_reset();
        init_to_stream();

        // Table-driven packets
        for (int i = 0; i < 6; i++) begin
            rx(tbl[i].b0);
            check("tbl_pv_b0", 32'(PacketValid), 32'd0);
            rx(tbl[i].b1);
            check("tbl_pv_b1", 32'(PacketValid), 32'd0);
            rx(tbl[i].b2);
            check("tbl_pv", 32'(PacketValid), 32'd1);
            check("tbl_btn", 32'(Buttons), 32'(tbl[i].btn));
            check("tbl_dx", 32'(DeltaX), 32'(tbl[i].dx));
            check("tbl_dy", 32'(DeltaY), 32'(tbl[i].dy));
            check("tbl_ovf", 32'(Overflow), 32'(tbl[i].ovf));
            step();
            check("tbl_pv_drop", 32'(PacketValid), 32'd0);
            check("tbl_dx_hold", 32'(DeltaX), 32'(tbl[i].dx));
        end

        // Resync: discard a header without bit 3, then drop a stale partial
        rx(8'h01);
        check("resync_junk_pv", 32'(PacketValid), 32'd0);
        rx(8'h09);
        rx(8'h05);
        check("resync_after_junk_b1", 32'(PacketValid), 32'd0);
        rx(8'hFB);
        check_pkt("resync_after_junk", 8'h09, 8'h05, 8'hFB);
        rx(8'h08);
        repeat (TO + 5) step();
        rx(8'h08);
        rx(8'h00);
        check("resync_no_early", 32'(PacketValid), 32'd0);
        rx(8'h00);
        check_pkt("resync_zero", 8'h08, 8'h00, 8'h00);
        check("resync_zero_ready", 32'(Ready), 32'd1);

        // Randomized packets with junk headers, gaps and abandoned partials
        for (int p = 0; p < 30; p++) begin
            logic [7:0] b0, b1, b2;
            if ($urandom_range(0, 3) == 0) begin
                rx(8'($urandom) & 8'hF7);
                check("rand_junk_pv", 32'(PacketValid), 32'd0);
            end
            if ($urandom_range(0, 5) == 0) begin
                rx(8'($urandom) | 8'h08);
                if ($urandom_range(0, 1) == 1) rx(8'($urandom));
                check("rand_partial_pv", 32'(PacketValid), 32'd0);
                repeat (TO + 10) step();
            end
            b0 = 8'($urandom) | 8'h08;
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            rx(b0);
            repeat ($urandom_range(0, 4)) step();
            rx(b1);
            repeat ($urandom_range(0, 4)) step();
            rx(b2);
            check_pkt("rand", b0, b1, b2);
            repeat ($urandom_range(1, 6)) step();
        end

        // Resend of the enable command, entered via reset from STREAM
        do_reset();
        txdone();
        rx(8'hFA);
        rx(8'hAA);
        rx(8'h00);
        wait_start(8'hF4, "rs_en_start");
        txdone();
        rx(8'hFE);
        wait_start(8'hF4, "resend_start");
        txdone();
        rx(8'hFA);
        check("resend_ready", 32'(Ready), 32'd1);

        // Tie: ACK lands in the timeout cycle; then spend the full retry budget
        do_reset();
        txdone();
        repeat (TO) step();
        rx(8'hFA);
        rx(8'hAA);
        rx(8'h00);
        wait_start(8'hF4, "tie_adv");
        txerr();
        wait_start(8'hFF, "retry1");
        txerr();
        wait_start(8'hFF, "retry2");
        txerr();
        wait_start(8'hFF, "retry3");
        check("retry3_no_error", 32'(Error), 32'd0);
        txerr();
        step();
        check("retry4_error", 32'(Error), 32'd1);
        check("retry4_ready", 32'(Ready), 32'd0);

        // Silent device: four resets sent, then permanent failure
        begin
            int starts = 1;
            do_reset();
            txdone();
            for (int i = 0; i < 1000; i++) begin
                if (TxStart) begin
                    starts++;
                    check("silent_data", 32'(TxData), 32'hFF);
                    txdone();
                end else begin
                    step();
                end
            end
            check("silent_starts", 32'(starts), 32'(MR + 1));
            check("silent_error", 32'(Error), 32'd1);
            check("silent_ready", 32'(Ready), 32'd0);
            starts = 0;
            rx(8'hFA);
            txdone();
            for (int i = 0; i < 200; i++) begin
                if (TxStart) starts++;
                step();
            end
            check("fail_no_txstart", 32'(starts), 32'd0);
            check("fail_sticky", 32'(Error), 32'd1);
            do_reset();
            check("error_cleared", 32'(Error), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
